// File: rtl/byte_unstrip_pkg.sv
// Purpose: shared widths, FSM state type and lane-select helper for byte_unstrip.
// Contents: LANES, BITS, GROUP_W, IDX_W, state_e, lane_sel().
package byte_unstrip_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned BITS    = 8;
    localparam int unsigned GROUP_W = LANES * BITS;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Pick byte lane idx out of a packed group {LANE3..LANE0}.
    function automatic logic [BITS-1:0] lane_sel(input logic [GROUP_W-1:0] grp,
                                                 input logic [IDX_W-1:0]   idx);
        return grp[32'(idx) * BITS +: BITS];
    endfunction

endpackage

// File: rtl/byte_unstrip_fifo.sv
// Purpose: synchronous group FIFO with combinational head read.
// Ports: CLK, RESET (sync, active-high), push, pop, din (group in),
//        dout (head group), count (occupancy 0..DEPTH).
module unstrip_fifo
    import byte_unstrip_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               push,
    input  logic               pop,
    input  logic [GROUP_W-1:0] din,
    output logic [GROUP_W-1:0] dout,
    output logic [CNT_W-1:0]   count
);

    logic [GROUP_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = ptr_inc(wr_q);
        if (pop)  rd_d = ptr_inc(rd_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push && !RESET) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/byte_unstrip.sv
// Purpose: re-serialize 4-lane byte groups into one byte per clock, LANE0 first.
// Ports: CLK, RESET (sync, active-high), LANE0..LANE3 + i_DK (group in),
//        READY (group accepted this cycle), D + o_DK (registered byte out),
//        ERR (sticky: a group arrived while READY was low).
module byte_unstrip
    import byte_unstrip_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] LANE0,
    input  logic [BITS-1:0] LANE1,
    input  logic [BITS-1:0] LANE2,
    input  logic [BITS-1:0] LANE3,
    input  logic            i_DK,
    output logic            READY,
    output logic [BITS-1:0] D,
    output logic            o_DK,
    output logic            ERR
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BITS-1:0]    d_q;
    logic               dk_q;
    logic               err_q;

    logic [GROUP_W-1:0] head_c;
    logic [CNT_W-1:0]   count_c;
    logic               push_c;
    logic               pop_c;
    logic               emit_c;
    logic               ovf_c;

    // READY looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign READY  = !RESET && (count_c < CNT_W'(DEPTH));
    assign push_c = i_DK && READY;
    assign ovf_c  = i_DK && !READY && !RESET;

    // IDLE with data emits LANE0 right away so the first byte lands one edge after the push.
    assign emit_c = !RESET && ((state_q == ST_SHIFT) || (count_c != '0));
    assign pop_c  = emit_c && (idx_q == IDX_W'(3));

    unstrip_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push_c),
        .pop   (pop_c),
        .din   ({LANE3, LANE2, LANE1, LANE0}),
        .dout  (head_c),
        .count (count_c)
    );

    // Serializer FSM with registered byte output and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            d_q     <= '0;
            dk_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            d_q  <= '0;
            dk_q <= 1'b0;
            if (ovf_c) err_q <= 1'b1;
            if (emit_c) begin
                d_q  <= lane_sel(head_c, idx_q);
                dk_q <= 1'b1;
                if (pop_c) begin
                    idx_q <= '0;
                    // Occupancy after this pop is nonzero if another group was queued or arrives now.
                    state_q <= ((count_c > CNT_W'(1)) || push_c) ? ST_SHIFT : ST_IDLE;
                end else begin
                    idx_q   <= idx_q + IDX_W'(1);
                    state_q <= ST_SHIFT;
                end
            end
        end
    end

    assign D    = d_q;
    assign o_DK = dk_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_byte_unstrip.sv
module tb_byte_unstrip;

    logic       clk;
    logic       rst2, rst1;
    logic       dk2, dk1;
    logic [7:0] l0, l1, l2, l3;
    logic       ready2, ready1;
    logic [7:0] d2, d1;
    logic       odk2, odk1;
    logic       err2, err1;

    logic [7:0] q2 [$];
    logic [7:0] q1 [$];

    int n_checks = 0;
    int n_errors = 0;

    byte_unstrip #(.DEPTH(2)) u_dut2 (
        .CLK(clk), .RESET(rst2),
        .LANE0(l0), .LANE1(l1), .LANE2(l2), .LANE3(l3),
        .i_DK(dk2), .READY(ready2), .D(d2), .o_DK(odk2), .ERR(err2)
    );

    byte_unstrip #(.DEPTH(1)) u_dut1 (
        .CLK(clk), .RESET(rst1),
        .LANE0(l0), .LANE1(l1), .LANE2(l2), .LANE3(l3),
        .i_DK(dk1), .READY(ready1), .D(d1), .o_DK(odk1), .ERR(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop an expected byte for each valid output, require zero otherwise.
    task automatic mon();
        if (odk2) begin
            if (q2.size() == 0) chk("d2_unexpected_byte", {24'd0, d2}, 32'hFFFF_FFFF);
            else chk("d2_data", {24'd0, d2}, {24'd0, q2.pop_front()});
        end else begin
            chk("d2_zero_when_idle", {24'd0, d2}, 32'd0);
        end
        if (odk1) begin
            if (q1.size() == 0) chk("d1_unexpected_byte", {24'd0, d1}, 32'hFFFF_FFFF);
            else chk("d1_data", {24'd0, d1}, {24'd0, q1.pop_front()});
        end else begin
            chk("d1_zero_when_idle", {24'd0, d1}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic set_lanes(input logic [7:0] a, b, c, d);
        l0 = a; l1 = b; l2 = c; l3 = d;
    endtask

    task automatic exp2(input logic [7:0] a, b, c, d);
        q2.push_back(a); q2.push_back(b); q2.push_back(c); q2.push_back(d);
    endtask

    task automatic exp1(input logic [7:0] a, b, c, d);
        q1.push_back(a); q1.push_back(b); q1.push_back(c); q1.push_back(d);
    endtask

    initial begin
        rst2 = 1'b1; rst1 = 1'b1; dk2 = 1'b1; dk1 = 1'b0;
        set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD);

        // Reset held two cycles with i_DK high: nothing may be captured.
        tick();
        tick();
        chk("rst_ready", {31'd0, ready2}, 32'd0);
        chk("rst_odk", {31'd0, odk2}, 32'd0);
        chk("rst_err", {31'd0, err2}, 32'd0);
        dk2 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, ready2}, 32'd1);
        repeat (3) tick();
        chk("rst_no_output", {31'd0, odk2}, 32'd0);

        // Single group: bytes one edge after the push, then idle.
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
        exp2(8'h11, 8'h22, 8'h33, 8'h44);
        dk2 = 1'b1;
        tick();
        dk2 = 1'b0;
        chk("single_no_output_at_push", {31'd0, odk2}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_odk", {31'd0, odk2}, 32'd1);
        end
        tick();
        chk("single_odk_after", {31'd0, odk2}, 32'd0);
        chk("single_q_drained", q2.size(), 32'd0);

        // Back-to-back groups four cycles apart: eight gapless bytes.
        set_lanes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        exp2(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        dk2 = 1'b1;
        tick();
        dk2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_odk_a", {31'd0, odk2}, 32'd1);
        end
        set_lanes(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        exp2(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        dk2 = 1'b1;
        tick();
        chk("b2b_odk_a3", {31'd0, odk2}, 32'd1);
        dk2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_odk_b", {31'd0, odk2}, 32'd1);
        end
        tick();
        chk("b2b_odk_after", {31'd0, odk2}, 32'd0);
        chk("b2b_q_drained", q2.size(), 32'd0);

        // Overflow: three groups on consecutive edges into a 2-deep FIFO.
        dk2 = 1'b1;
        set_lanes(8'h01, 8'h02, 8'h03, 8'h04);
        exp2(8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        chk("ovf_ready_after_1", {31'd0, ready2}, 32'd1);
        set_lanes(8'h05, 8'h06, 8'h07, 8'h08);
        exp2(8'h05, 8'h06, 8'h07, 8'h08);
        tick();
        chk("ovf_ready_after_2", {31'd0, ready2}, 32'd0);
        chk("ovf_err_before", {31'd0, err2}, 32'd0);
        set_lanes(8'h09, 8'h0A, 8'h0B, 8'h0C);
        tick();
        dk2 = 1'b0;
        chk("ovf_err_set", {31'd0, err2}, 32'd1);
        repeat (10) tick();
        chk("ovf_err_sticky", {31'd0, err2}, 32'd1);
        chk("ovf_q_drained", q2.size(), 32'd0);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("ovf_err_cleared", {31'd0, err2}, 32'd0);

        // Reset after the second byte: remaining bytes are discarded.
        set_lanes(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        exp2(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        dk2 = 1'b1;
        tick();
        dk2 = 1'b0;
        tick();
        tick();
        q2.delete();
        rst2 = 1'b1;
        tick();
        chk("midrst_odk", {31'd0, odk2}, 32'd0);
        chk("midrst_d", {24'd0, d2}, 32'd0);
        rst2 = 1'b0;
        repeat (6) tick();
        chk("midrst_no_resume", {31'd0, odk2}, 32'd0);
        chk("midrst_ready", {31'd0, ready2}, 32'd1);

        // DEPTH=1: push on the edge LANE3 leaves is rejected.
        set_lanes(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        exp1(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        dk1 = 1'b1;
        tick();
        dk1 = 1'b0;
        chk("d1_ready_full", {31'd0, ready1}, 32'd0);
        repeat (3) tick();
        set_lanes(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        dk1 = 1'b1;
        tick();
        dk1 = 1'b0;
        chk("d1_last_byte", {31'd0, odk1}, 32'd1);
        chk("d1_err_rejected", {31'd0, err1}, 32'd1);
        repeat (6) tick();
        chk("d1_q_drained", q1.size(), 32'd0);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;

        // DEPTH=1: push one cycle later is accepted.
        set_lanes(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        exp1(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        dk1 = 1'b1;
        tick();
        dk1 = 1'b0;
        repeat (4) tick();
        set_lanes(8'hF0, 8'hF1, 8'hF2, 8'hF3);
        exp1(8'hF0, 8'hF1, 8'hF2, 8'hF3);
        dk1 = 1'b1;
        tick();
        dk1 = 1'b0;
        chk("d1_err_accepted", {31'd0, err1}, 32'd0);
        repeat (6) tick();
        chk("d1_q_drained2", q1.size(), 32'd0);
        chk("d1_err_final", {31'd0, err1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
